perf_ctrl: RTL and testbench
============================

Name: perf_ctrl

Overview:
- Master-side sequencer for a perf counter bank, driving the master modport of `perf_if`.
- Accepts clear, toggle and dump commands from a CSR/MMIO front end.
- Streams a frozen snapshot of all counters over a valid/ready port. For dumps while counting, it pauses the bank first and resumes it afterwards.
- Optionally raises periodic auto-dumps from an internal sample timer.

Parameters:
- PERF_REG_NUM, 1, number of counters in the bank (matches `perf_if` `perf_reg_num`)
- CNT_W, 64, width of `perf_pkg::counter_t`
- SAMPLE_PERIOD, 0, auto-dump interval in cycles; 0 disables the timer
- IDX_W, $clog2(PERF_REG_NUM)>0 ? $clog2(PERF_REG_NUM) : 1, width of `out_idx`

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_op  in  2  00 NOP, 01 CLEAR, 10 TOGGLE, 11 DUMP
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- clear_trigger  out  1  to `perf_if`; 1-cycle pulse clears all counters
- toggle_trigger  out  1  to `perf_if`; 1-cycle pulse flips the bank's run state
- counter_r  in  PERF_REG_NUM x CNT_W  from `perf_if` counter array
- out_valid  out  1  snapshot beat valid
- out_ready  in  1  consumer ready
- out_data  out  CNT_W  counter value
- out_idx  out  IDX_W  counter index
- out_last  out  1  final beat of dump
- running  out  1  controller's view of bank run state
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. Outputs cmd_ready=0 in the reset cycle, clear_trigger=0, toggle_trigger=0, out_valid=0, out_data=0, out_idx=0, out_last=0, running=0, busy=0. Timer=0, auto_pend=0. The bank is stopped out of reset.
- State machine: IDLE, CLR, TGL, PAUSE, SETTLE, STREAM, RESUME.
- IDLE:
  - cmd_ready=1 unless auto_pend=1; auto_pend has priority and cmd_ready=0 that cycle.
  - auto_pend=1 -> PAUSE if running, else STREAM; auto_pend clears.
  - Accepted CLEAR -> CLR; TOGGLE -> TGL; DUMP -> PAUSE if running, else STREAM; NOP is accepted with no effect.
- CLR: clear_trigger=1 for exactly this cycle; timer=0; running unchanged; -> IDLE.
- TGL: toggle_trigger=1 for this cycle; running flips at the next edge; -> IDLE.
- PAUSE: toggle_trigger=1; running<=0; -> SETTLE.
- SETTLE: one idle cycle so the bank's last increment lands; -> STREAM with beat index=0.
- STREAM:
  - out_valid=1, out_data=counter_r[idx], out_idx=idx, out_last=(idx==PERF_REG_NUM-1).
  - out_data/out_idx/out_last are held stable while out_valid&!out_ready.
  - On handshake: if last, go to RESUME if the dump began with running=1 (resume flag latched on entry), else IDLE; otherwise idx+1.
  - PERF_REG_NUM=1 gives a single beat with out_last=1.
- RESUME: toggle_trigger=1; running<=1; -> IDLE.
- clear_trigger and toggle_trigger are never both 1 in one cycle.
- busy=1 in every state except IDLE.
- Timer (SAMPLE_PERIOD>0 only):
  - Increments each cycle while running=1 and state==IDLE; holds otherwise.
  - Reaching SAMPLE_PERIOD-1 sets auto_pend and reloads timer to 0.
  - A second expiry while auto_pend=1 is dropped, not queued.
  - CLEAR also clears auto_pend.
- SAMPLE_PERIOD=0: timer and auto_pend are held at 0.
- The dump sequence is uninterruptible. Commands arriving while busy wait; cmd_ready=0 and the command is not dropped.
- Reset mid-dump: returns to IDLE with all outputs at reset values and running=0. The controller does not pulse toggle_trigger; the bank owner resets the bank on the same rst.

Test Plan:
- Reset then DUMP with PERF_REG_NUM=4, counter_r={10,20,30,40}, running=0 -> 4 beats idx 0..3 with data 10,20,30,40; out_last only on idx 3; no toggle_trigger pulses.
- TOGGLE then DUMP -> toggle pulse, running=1; then PAUSE toggle, one SETTLE cycle, 4 beats, RESUME toggle (3 toggle pulses total); running=1 at end.
- DUMP with out_ready low for 5 cycles on beat 1 -> out_valid held, out_idx=1 and out_data stable; no beat skipped or duplicated.
- CLEAR while busy streaming -> cmd_ready=0 until IDLE; then clear_trigger high for exactly 1 cycle; running unchanged.
- SAMPLE_PERIOD=8, running=1, no commands -> auto-dump starts 8 IDLE cycles after running asserts; a DUMP cmd in the same cycle waits until after the auto-dump.
- Assert rst during STREAM beat 2 -> next cycle out_valid=0, busy=0, running=0, cmd_ready=1.

Source files
------------

// File: rtl/perf_ctrl.sv
// Sequencer for a perf counter bank: clear/toggle commands, paused snapshot dumps over valid/ready, optional periodic auto-dump.
// Triggers are single-cycle pulses; the dump sequence is uninterruptible and commands wait on cmd_ready.
module perf_ctrl #(
   parameter int PERF_REG_NUM  = 1,
   parameter int CNT_W         = 64,
   parameter int SAMPLE_PERIOD = 0,
   parameter int IDX_W         = $clog2(PERF_REG_NUM) > 0 ? $clog2(PERF_REG_NUM) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               cmd_valid,
   input  logic [1:0]                         cmd_op,
   output logic                               cmd_ready,
   output logic                               clear_trigger,
   output logic                               toggle_trigger,
   input  logic [PERF_REG_NUM-1:0][CNT_W-1:0] counter_r,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [CNT_W-1:0]                   out_data,
   output logic [IDX_W-1:0]                   out_idx,
   output logic                               out_last,
   output logic                               running,
   output logic                               busy
);

   localparam int TMR_W = SAMPLE_PERIOD > 1 ? $clog2(SAMPLE_PERIOD) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PERF_REG_NUM - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(SAMPLE_PERIOD > 0 ? SAMPLE_PERIOD - 1 : 0);

   localparam logic [1:0] OP_CLEAR  = 2'b01;
   localparam logic [1:0] OP_TOGGLE = 2'b10;
   localparam logic [1:0] OP_DUMP   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_TGL, S_PAUSE, S_SETTLE, S_STREAM, S_RESUME
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             running_q, running_d;
   logic             resume_q, resume_d;
   logic             auto_pend_q, auto_pend_d;
   logic             expire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         timer_q     <= '0;
         running_q   <= 1'b0;
         resume_q    <= 1'b0;
         auto_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         timer_q     <= timer_d;
         running_q   <= running_d;
         resume_q    <= resume_d;
         auto_pend_q <= auto_pend_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      timer_d        = timer_q;
      running_d      = running_q;
      resume_d       = resume_q;
      auto_pend_d    = auto_pend_q;
      expire         = 1'b0;
      cmd_ready      = 1'b0;
      clear_trigger  = 1'b0;
      toggle_trigger = 1'b0;
      out_valid      = 1'b0;
      out_data       = '0;
      out_idx        = '0;
      out_last       = 1'b0;
      busy           = (state_q != S_IDLE);
      running        = running_q;

      // Sample timer only advances while the bank counts and nothing else is in flight.
      if (SAMPLE_PERIOD > 0 && state_q == S_IDLE && running_q) begin
         if (timer_q == TMR_MAX) begin
            timer_d = '0;
            expire  = 1'b1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            cmd_ready = !auto_pend_q;
            if (auto_pend_q) begin
               auto_pend_d = 1'b0;
               resume_d    = running_q;
               idx_d       = '0;
               state_d     = running_q ? S_PAUSE : S_STREAM;
            end else begin
               auto_pend_d = expire;
               if (cmd_valid) begin
                  case (cmd_op)
                     OP_CLEAR:  state_d = S_CLR;
                     OP_TOGGLE: state_d = S_TGL;
                     OP_DUMP: begin
                        resume_d = running_q;
                        idx_d    = '0;
                        state_d  = running_q ? S_PAUSE : S_STREAM;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_CLR: begin
            clear_trigger = 1'b1;
            timer_d       = '0;
            auto_pend_d   = 1'b0;
            state_d       = S_IDLE;
         end
         S_TGL: begin
            toggle_trigger = 1'b1;
            running_d      = !running_q;
            state_d        = S_IDLE;
         end
         S_PAUSE: begin
            toggle_trigger = 1'b1;
            running_d      = 1'b0;
            state_d        = S_SETTLE;
         end
         S_SETTLE: begin
            idx_d   = '0;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            out_valid = 1'b1;
            out_data  = counter_r[idx_q];
            out_idx   = idx_q;
            out_last  = (idx_q == LAST_IDX);
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = resume_q ? S_RESUME : S_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_RESUME: begin
            toggle_trigger = 1'b1;
            running_d      = 1'b1;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs read as reset values during reset so no stray pulse reaches the bank.
      if (rst) begin
         cmd_ready      = 1'b0;
         clear_trigger  = 1'b0;
         toggle_trigger = 1'b0;
         out_valid      = 1'b0;
         out_data       = '0;
         out_idx        = '0;
         out_last       = 1'b0;
         running        = 1'b0;
         busy           = 1'b0;
      end
   end

endmodule

// File: tb/tb_perf_ctrl.sv
// Bench for perf_ctrl: directed scenarios plus random traffic against a plan-queue reference model.
module tb_perf_ctrl;

   localparam int N  = 4;
   localparam int W  = 64;
   localparam int SP = 8;
   localparam int IW = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cmd_valid;
   logic [1:0]            cmd_op;
   logic                  cmd_ready;
   logic                  clear_trigger;
   logic                  toggle_trigger;
   logic [N-1:0][W-1:0]   counter_r;
   logic                  out_valid;
   logic                  out_ready;
   logic [W-1:0]          out_data;
   logic [IW-1:0]         out_idx;
   logic                  out_last;
   logic                  running;
   logic                  busy;

   always #5 clk = ~clk;

   perf_ctrl #(
      .PERF_REG_NUM (N),
      .CNT_W        (W),
      .SAMPLE_PERIOD(SP),
      .IDX_W        (IW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_op        (cmd_op),
      .cmd_ready     (cmd_ready),
      .clear_trigger (clear_trigger),
      .toggle_trigger(toggle_trigger),
      .counter_r     (counter_r),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_idx       (out_idx),
      .out_last      (out_last),
      .running       (running),
      .busy          (busy)
   );

   // Each accepted command expands into the list of cycles it will occupy.
   typedef enum {K_CLR, K_TGL, K_SETTLE, K_BEAT} kind_e;
   typedef struct {
      kind_e kind;
      int    arg;   // K_TGL: 0 flip, 1 stop, 2 start; K_BEAT: counter index
   } item_t;

   item_t plan[$];
   bit    m_run, m_pend, m_acc, rand_rdy;
   int    m_tick, stall_left;
   int    n_chk, n_fail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic item_t mk(input kind_e k, input int a);
      item_t it;
      it.kind = k;
      it.arg  = a;
      return it;
   endfunction

   function automatic void push_dump();
      if (m_run) begin
         plan.push_back(mk(K_TGL, 1));
         plan.push_back(mk(K_SETTLE, 0));
      end
      for (int i = 0; i < N; i++) plan.push_back(mk(K_BEAT, i));
      if (m_run) plan.push_back(mk(K_TGL, 2));
   endfunction

   task automatic eval_cycle();
      bit          idle, expire;
      bit          e_rdy, e_clr, e_tgl, e_vld, e_last;
      logic [63:0] e_dat;
      int          e_idx;
      item_t       h;
      idle   = (plan.size() == 0);
      e_rdy  = 0; e_clr = 0; e_tgl = 0; e_vld = 0; e_last = 0;
      e_dat  = '0; e_idx = 0;
      expire = 0;
      if (!rst) begin
         if (idle) e_rdy = !m_pend;
         else begin
            h = plan[0];
            case (h.kind)
               K_CLR: e_clr = 1;
               K_TGL: e_tgl = 1;
               K_BEAT: begin
                  e_vld  = 1;
                  e_idx  = h.arg;
                  e_dat  = counter_r[h.arg];
                  e_last = (h.arg == N - 1);
               end
               default: ;
            endcase
         end
      end
      chk("cmd_ready", cmd_ready, e_rdy);
      chk("clear_trigger", clear_trigger, e_clr);
      chk("toggle_trigger", toggle_trigger, e_tgl);
      chk("out_valid", out_valid, e_vld);
      chk("running", running, rst ? 1'b0 : m_run);
      chk("busy", busy, !rst && !idle);
      if (e_vld || rst) begin
         chk("out_data", out_data, e_dat);
         chk("out_idx", out_idx, 64'(e_idx));
         chk("out_last", out_last, e_last);
      end

      m_acc = 0;
      if (rst) begin
         plan.delete();
         m_run  = 0;
         m_pend = 0;
         m_tick = 0;
         return;
      end
      if (idle) begin
         if (m_run) begin
            m_tick++;
            if (m_tick == SP) begin
               m_tick = 0;
               expire = 1;
            end
         end
         if (m_pend) begin
            m_pend = 0;
            push_dump();
         end else begin
            m_pend = expire;
            if (cmd_valid) begin
               m_acc = 1;
               case (cmd_op)
                  2'b01: plan.push_back(mk(K_CLR, 0));
                  2'b10: plan.push_back(mk(K_TGL, 0));
                  2'b11: push_dump();
                  default: ;
               endcase
            end
         end
      end else begin
         h = plan[0];
         case (h.kind)
            K_CLR: begin
               m_pend = 0;
               m_tick = 0;
               void'(plan.pop_front());
            end
            K_TGL: begin
               m_run = (h.arg == 0) ? !m_run : (h.arg == 2);
               void'(plan.pop_front());
            end
            K_SETTLE: void'(plan.pop_front());
            K_BEAT: if (out_ready) void'(plan.pop_front());
            default: ;
         endcase
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      eval_cycle();
      @(posedge clk);
      #1;
      if (m_run) begin
         for (int i = 0; i < N; i++) counter_r[i] = counter_r[i] + 64'($urandom_range(1, 5));
      end
      if (stall_left > 0 && plan.size() > 0 && plan[0].kind == K_BEAT && plan[0].arg == 1) begin
         out_ready = 0;
         stall_left--;
      end else begin
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic send(input logic [1:0] op);
      int t;
      cmd_valid = 1;
      cmd_op    = op;
      t = 0;
      do begin
         cycle();
         t++;
      end while (!m_acc && t < 200);
      chk("cmd_accept", m_acc, 1);
      cmd_valid = 0;
      cmd_op    = 2'b00;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         cycle();
         t++;
      end while ((plan.size() != 0 || m_pend) && t < 200);
   endtask

   task automatic do_reset();
      rst = 1;
      repeat (2) cycle();
      rst = 0;
   endtask

   initial begin
      int t;
      n_chk = 0; n_fail = 0;
      m_run = 0; m_pend = 0; m_tick = 0; m_acc = 0;
      rand_rdy = 0; stall_left = 0;
      cmd_valid = 0; cmd_op = 2'b00; out_ready = 1;
      counter_r[0] = 64'd10;
      counter_r[1] = 64'd20;
      counter_r[2] = 64'd30;
      counter_r[3] = 64'd40;
      do_reset();

      // Stopped bank: plain 4-beat dump with the reset-time values.
      send(2'b11);
      wait_idle();

      // Start the bank, then a dump that pauses and resumes it.
      send(2'b10);
      send(2'b11);
      wait_idle();

      // Back-pressure on beat 1.
      stall_left = 5;
      send(2'b11);
      wait_idle();

      // CLEAR queued behind a dump in progress.
      send(2'b11);
      send(2'b01);
      wait_idle();

      // Auto-dump timing from a fresh start, with a DUMP arriving near expiry.
      do_reset();
      send(2'b10);
      repeat (7) cycle();
      send(2'b11);
      wait_idle();
      send(2'b10);
      wait_idle();

      // Reset during beat 2 of a stopped-bank dump.
      send(2'b11);
      t = 0;
      while (!(plan.size() > 0 && plan[0].kind == K_BEAT && plan[0].arg == 2) && t < 50) begin
         cycle();
         t++;
      end
      chk("reach_beat2", (t < 50), 1);
      rst = 1;
      cycle();
      rst = 0;
      repeat (3) cycle();

      // Random traffic.
      rand_rdy = 1;
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (m_acc) cmd_valid = 0;
         if (!cmd_valid && $urandom_range(0, 3) == 0) begin
            cmd_valid = 1;
            cmd_op    = 2'($urandom_range(0, 3));
         end
         rst = ($urandom_range(0, 499) == 0);
      end
      rst = 0;
      cmd_valid = 0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
